// File: rtl/fp_round_pkg.sv
// Shared types and constants for the binary32 normalize/round/pack pipeline.
package fp_round_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rm_e;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam int          EXP_MAX = 255;
  localparam logic [31:0] MAXFIN  = 32'h7F7F_FFFF;
  localparam logic [31:0] PINF    = 32'h7F80_0000;

  // Everything stage 2 needs to round and pack one operation.
  typedef struct packed {
    logic        sign;
    logic [47:0] norm;
    logic        sticky;
    logic [8:0]  exp;
    logic        is_zero;
    logic        both_zero;
    rm_e         rm;
    logic        special;
    logic [31:0] special_val;
    logic [4:0]  special_flags;
  } s1_payload_t;

endpackage

// File: rtl/fp_norm_round_r4_lzc48.sv
// Combinational leading-zero counter for the 48-bit mantissa; 48 when all zero.
module lzc48 (
  input  logic [47:0] mant,
  output logic [5:0]  count
);

  // Scanning upward lets the highest set bit have the final say.
  always_comb begin
    count = 6'd48;
    for (int i = 0; i < 48; i++) begin
      if (mant[i]) count = 6'(47 - i);
    end
  end

endmodule

// File: rtl/fp_norm_round_r4.sv
// Two-stage normalize then round/pack unit for the binary32 add/sub datapath,
// with an in-order bypass lane for upstream special results.
module fp_norm_round_r4 #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_carry,
  input  logic [47:0]      in_mant,
  input  logic             in_sign,
  input  logic             in_sticky,
  input  logic [8:0]       in_exp,
  input  logic             in_both_zero,
  input  logic [2:0]       in_rm,
  input  logic             in_special,
  input  logic [31:0]      in_special_val,
  input  logic [4:0]       in_special_flags,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_flags,
  output logic [TAG_W-1:0] out_tag
);

  import fp_round_pkg::*;

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_adv;
  s1_payload_t      s1_q;
  s1_payload_t      s1_d;
  logic [TAG_W-1:0] s1_tag;

  logic [5:0]  lz;
  logic [8:0]  lz9;
  logic [8:0]  exp_m1;
  logic [8:0]  sh9;
  logic [47:0] norm;
  logic        stk;
  logic [8:0]  exp_n;

  logic [23:0] sig;
  logic        guard;
  logic        st;
  logic        inc;
  logic [24:0] sum;
  logic [22:0] frac_r;
  logic [9:0]  exp_r;
  logic        nx;
  logic        to_inf;
  logic [31:0] res_d;
  logic [4:0]  flags_d;

  assign s1_adv    = ~s2_valid | out_ready;
  assign in_ready  = ~s1_valid | s1_adv;
  assign out_valid = s2_valid;

  lzc48 u_lzc (
    .mant  (in_mant),
    .count (lz)
  );

  // Normalize: a carry costs one right shift; otherwise shift left, but never
  // below exponent 1 so that small results land in subnormal position.
  always_comb begin
    lz9    = {3'b000, lz};
    exp_m1 = in_exp - 9'd1;
    sh9    = '0;
    norm   = in_mant;
    stk    = in_sticky;
    exp_n  = in_exp;
    if (in_carry) begin
      norm  = {1'b1, in_mant[47:1]};
      stk   = in_sticky | in_mant[0];
      exp_n = in_exp + 9'd1;
    end else begin
      if (in_exp != 9'd0) sh9 = (lz9 < exp_m1) ? lz9 : exp_m1;
      norm  = in_mant << sh9[5:0];
      exp_n = (in_exp <= lz9) ? 9'd0 : in_exp - sh9;
    end

    s1_d               = '0;
    s1_d.sign          = in_sign;
    s1_d.norm          = norm;
    s1_d.sticky        = stk;
    s1_d.exp           = exp_n;
    s1_d.is_zero       = ~in_carry & (in_mant == 48'd0) & ~in_sticky;
    s1_d.both_zero     = in_both_zero;
    s1_d.rm            = rm_e'(in_rm);
    s1_d.special       = in_special;
    s1_d.special_val   = in_special_val;
    s1_d.special_flags = in_special_flags;
  end

  // Round and pack. A subnormal that rounds up into the hidden-bit position
  // becomes the smallest normal number.
  always_comb begin
    sig   = s1_q.norm[47:24];
    guard = s1_q.norm[23];
    st    = (|s1_q.norm[22:0]) | s1_q.sticky;
    case (s1_q.rm)
      RNE:     inc = guard & (st | sig[0]);
      RTZ:     inc = 1'b0;
      RDN:     inc = (guard | st) & s1_q.sign;
      RUP:     inc = (guard | st) & ~s1_q.sign;
      RMM:     inc = guard;
      default: inc = 1'b0;
    endcase

    sum = {1'b0, sig} + {24'd0, inc};
    if (sum[24]) begin
      frac_r = sum[23:1];
      exp_r  = {1'b0, s1_q.exp} + 10'd1;
    end else begin
      frac_r = sum[22:0];
      exp_r  = {1'b0, s1_q.exp};
      if (s1_q.exp == 9'd0 && sum[23]) exp_r = 10'd1;
    end

    nx     = guard | st;
    to_inf = (s1_q.rm == RNE) | (s1_q.rm == RMM) |
             ((s1_q.rm == RUP) & ~s1_q.sign) | ((s1_q.rm == RDN) & s1_q.sign);

    res_d            = {s1_q.sign, exp_r[7:0], frac_r};
    flags_d          = '0;
    flags_d[FLAG_NX] = nx;
    flags_d[FLAG_UF] = nx & (exp_r == 10'd0);

    if (s1_q.special) begin
      res_d   = s1_q.special_val;
      flags_d = s1_q.special_flags;
    end else if (s1_q.is_zero) begin
      res_d   = {(s1_q.both_zero ? s1_q.sign : (s1_q.rm == RDN)), 31'd0};
      flags_d = '0;
    end else if (exp_r >= 10'(EXP_MAX)) begin
      res_d            = {s1_q.sign, (to_inf ? PINF[30:0] : MAXFIN[30:0])};
      flags_d          = '0;
      flags_d[FLAG_OF] = 1'b1;
      flags_d[FLAG_NX] = 1'b1;
    end
  end

  // Stage 2 only loads when it is empty or being drained, which keeps the
  // outputs frozen under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1_q       <= '0;
      s1_tag     <= '0;
      out_result <= '0;
      out_flags  <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_result <= res_d;
          out_flags  <= flags_d;
          out_tag    <= s1_tag;
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_q   <= s1_d;
          s1_tag <= in_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_round_r4.sv
// Randomized scoreboard bench for fp_norm_round_r4 with an arithmetic reference
// model, plus directed vectors with hand-computed results.
module tb_fp_norm_round_r4;

  localparam int TAG_W = 5;

  typedef struct packed {
    logic             carry;
    logic [47:0]      mant;
    logic             sign;
    logic             sticky;
    logic [8:0]       exp;
    logic             both_zero;
    logic [2:0]       rm;
    logic             special;
    logic [31:0]      sval;
    logic [4:0]       sflags;
    logic [TAG_W-1:0] tag;
  } op_t;

  typedef struct packed {
    logic [31:0]      res;
    logic [4:0]       flags;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_result;
  logic [4:0]       out_flags;
  logic [TAG_W-1:0] out_tag;
  op_t              cur_op = '0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   cyc = 0;
  int   accepts = 0;
  int   pops = 0;
  int   last_acc_cyc = 0;
  int   last_pop_cyc = 0;
  logic [31:0]      last_res = '0;
  logic [4:0]       last_flags = '0;
  logic [TAG_W-1:0] last_tag = '0;
  logic             stall_prev = 1'b0;
  logic [41:0]      held = '0;

  always #5 clk = ~clk;

  fp_norm_round_r4 #(.TAG_W(TAG_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_carry         (cur_op.carry),
    .in_mant          (cur_op.mant),
    .in_sign          (cur_op.sign),
    .in_sticky        (cur_op.sticky),
    .in_exp           (cur_op.exp),
    .in_both_zero     (cur_op.both_zero),
    .in_rm            (cur_op.rm),
    .in_special       (cur_op.special),
    .in_special_val   (cur_op.sval),
    .in_special_flags (cur_op.sflags),
    .in_tag           (cur_op.tag),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_flags        (out_flags),
    .out_tag          (out_tag)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: locate the leading one, pick the lsb position of the 24-bit
  // significand (normal: 23 below the msb; subnormal: fixed by the exponent),
  // then round with ordinary integer arithmetic.
  function automatic exp_t model(input op_t o);
    exp_t        r;
    logic [63:0] full;
    logic [63:0] sig;
    int          p;
    int          lsb;
    int          e;
    logic        g;
    logic        st;
    logic        inc;
    logic        nx;
    logic        to_inf;
    r     = '0;
    r.tag = o.tag;
    if (o.special) begin
      r.res   = o.sval;
      r.flags = o.sflags;
      return r;
    end
    full = {15'd0, o.carry, o.mant};
    if (full == 64'd0 && !o.sticky) begin
      r.res = {(o.both_zero ? o.sign : (o.rm == 3'd2)), 31'd0};
      return r;
    end
    p = -1;
    for (int i = 0; i < 64; i++) if (full[i]) p = i;
    e = int'(o.exp) + p - 47;
    if (e < 1) e = 0;
    lsb = p - 23;
    if (25 - int'(o.exp) > lsb) lsb = 25 - int'(o.exp);
    if (lsb <= 0) begin
      sig = full << (-lsb);
      g   = 1'b0;
      st  = o.sticky;
    end else begin
      sig = full >> lsb;
      g   = full[lsb-1];
      st  = o.sticky | ((full & ((64'd1 << (lsb - 1)) - 64'd1)) != 64'd0);
    end
    case (o.rm)
      3'd0:    inc = g & (st | sig[0]);
      3'd2:    inc = (g | st) & o.sign;
      3'd3:    inc = (g | st) & ~o.sign;
      3'd4:    inc = g;
      default: inc = 1'b0;
    endcase
    sig = sig + {63'd0, inc};
    if (sig == 64'h100_0000) begin
      sig = sig >> 1;
      e   = e + 1;
    end
    if (e == 0 && sig[23]) e = 1;
    nx = g | st;
    if (e >= 255) begin
      to_inf  = (o.rm == 3'd0) || (o.rm == 3'd4) || (o.rm == 3'd3 && !o.sign) ||
                (o.rm == 3'd2 && o.sign);
      r.res   = to_inf ? {o.sign, 31'h7F80_0000} : {o.sign, 31'h7F7F_FFFF};
      r.flags = 5'b00101;
    end else begin
      r.res   = {o.sign, e[7:0], sig[22:0]};
      r.flags = {3'b000, nx && (e == 0), nx};
    end
    return r;
  endfunction

  // Single compare process: scoreboard pops, stall stability, and pushes for
  // whatever handshake will complete at the coming edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset || flush) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checkOutput("stall_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("stall_hold", {22'd0, out_result, out_flags, out_tag}, {22'd0, held});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_out", {63'd0, out_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("result", {32'd0, out_result}, {32'd0, e.res});
          checkOutput("flags", {59'd0, out_flags}, {59'd0, e.flags});
          checkOutput("tag", {59'd0, out_tag}, {59'd0, e.tag});
          pops++;
          last_pop_cyc = cyc;
          last_res     = out_result;
          last_flags   = out_flags;
          last_tag     = out_tag;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(cur_op));
        accepts++;
        last_acc_cyc = cyc;
      end
      stall_prev = out_valid && !out_ready;
      held       = {out_result, out_flags, out_tag};
    end
  end

  task automatic applyStimulus(input op_t o);
    cur_op = o;
  endtask

  task automatic sendOp(input op_t o);
    logic acc;
    acc = 1'b0;
    applyStimulus(o);
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  function automatic op_t mkOp(input logic carry, input logic [47:0] mant, input logic sign,
                               input logic sticky, input logic [8:0] exp, input logic bz,
                               input logic [2:0] rm, input logic [TAG_W-1:0] tag);
    op_t o;
    o           = '0;
    o.carry     = carry;
    o.mant      = mant;
    o.sign      = sign;
    o.sticky    = sticky;
    o.exp       = exp;
    o.both_zero = bz;
    o.rm        = rm;
    o.tag       = tag;
    return o;
  endfunction

  task automatic runDirected(input string name, input op_t o, input logic [31:0] res,
                             input logic [4:0] flags);
    int p0;
    out_ready = 1'b1;
    p0 = pops;
    sendOp(o);
    for (int k = 0; k < 10 && pops == p0; k++) begin
      @(posedge clk);
      #1;
    end
    if (pops == p0) begin
      checkOutput({name, "_timeout"}, 64'd0, 64'd1);
    end else begin
      checkOutput({name, "_res"}, {32'd0, last_res}, {32'd0, res});
      checkOutput({name, "_flags"}, {59'd0, last_flags}, {59'd0, flags});
    end
  endtask

  function automatic op_t genOp();
    op_t o;
    int  k;
    o      = '0;
    k      = $urandom_range(0, 15);
    o.sign = 1'($urandom);
    o.rm   = 3'($urandom_range(0, 4));
    o.tag  = TAG_W'($urandom);
    if (k == 0) begin
      o.special = 1'b1;
      o.sval    = $urandom;
      o.sflags  = 5'($urandom);
    end else if (k == 1) begin
      o.both_zero = 1'($urandom);
    end else begin
      o.carry = ($urandom_range(0, 3) == 0);
      o.mant  = {16'($urandom), $urandom} >> $urandom_range(0, 47);
      if ($urandom_range(0, 3) == 0) o.mant[22:0] = '0;
      if (!o.carry && o.mant == 48'd0) o.mant = 48'd1;
      o.sticky    = ($urandom_range(0, 2) == 0);
      o.both_zero = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       o.exp = 9'($urandom_range(1, 30));
        1:       o.exp = 9'($urandom_range(230, 254));
        default: o.exp = 9'($urandom_range(1, 254));
      endcase
    end
    return o;
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    op_t  o;
    logic acc;
    int   a0;
    int   p0;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_result", {32'd0, out_result}, 64'd0);
    checkOutput("rst_flags", {59'd0, out_flags}, 64'd0);
    checkOutput("rst_tag", {59'd0, out_tag}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    runDirected("basic", mkOp(1, 48'h0, 0, 0, 9'd127, 0, 3'd0, 5'd1), 32'h4000_0000, 5'b00000);
    checkOutput("latency", 64'(last_pop_cyc - last_acc_cyc), 64'd2);
    runDirected("canc_rne", mkOp(0, 48'h0, 1, 0, 9'd100, 0, 3'd0, 5'd2), 32'h0000_0000, 5'b00000);
    runDirected("canc_rdn", mkOp(0, 48'h0, 0, 0, 9'd100, 0, 3'd2, 5'd3), 32'h8000_0000, 5'b00000);
    runDirected("bz_rtz", mkOp(0, 48'h0, 1, 0, 9'd0, 1, 3'd1, 5'd4), 32'h8000_0000, 5'b00000);
    runDirected("bz_rup", mkOp(0, 48'h0, 1, 0, 9'd0, 1, 3'd3, 5'd5), 32'h8000_0000, 5'b00000);
    runDirected("tie_rne", mkOp(0, 48'h800001_800000, 0, 0, 9'd127, 0, 3'd0, 5'd6), 32'h3F80_0002, 5'b00001);
    runDirected("tie_rtz", mkOp(0, 48'h800001_800000, 0, 0, 9'd127, 0, 3'd1, 5'd7), 32'h3F80_0001, 5'b00001);
    runDirected("tie_rmm", mkOp(0, 48'h800001_800000, 0, 0, 9'd127, 0, 3'd4, 5'd8), 32'h3F80_0002, 5'b00001);
    runDirected("ovf_rne", mkOp(1, 48'hFFFFFF_000000, 0, 0, 9'd254, 0, 3'd0, 5'd9), 32'h7F80_0000, 5'b00101);
    runDirected("ovf_rtz", mkOp(1, 48'hFFFFFF_000000, 0, 0, 9'd254, 0, 3'd1, 5'd10), 32'h7F7F_FFFF, 5'b00101);
    runDirected("subn", mkOp(0, 48'h4000_0000_0000, 0, 0, 9'd1, 0, 3'd0, 5'd11), 32'h0040_0000, 5'b00000);
    runDirected("subn_uf", mkOp(0, 48'h4000_0000_0000, 0, 1, 9'd1, 0, 3'd0, 5'd12), 32'h0040_0000, 5'b00011);
    o = mkOp(1, 48'h123, 0, 1, 9'd200, 0, 3'd0, 5'd13);
    o.special = 1'b1;
    o.sval    = 32'h7FC0_0000;
    o.sflags  = 5'b10000;
    runDirected("special", o, 32'h7FC0_0000, 5'b10000);

    // Backpressure: three back-to-back offers against a stalled consumer.
    out_ready = 1'b0;
    a0 = accepts;
    applyStimulus(mkOp(0, 48'h900000_000000, 0, 0, 9'd120, 0, 3'd0, 5'd21));
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc && cur_op.tag == 5'd21)
        applyStimulus(mkOp(1, 48'h000100_000001, 1, 0, 9'd60, 0, 3'd3, 5'd22));
      else if (acc && cur_op.tag == 5'd22)
        applyStimulus(mkOp(0, 48'h000000_0F0000, 0, 1, 9'd40, 0, 3'd4, 5'd23));
    end
    checkOutput("bp_accepts", 64'(accepts - a0), 64'd2);
    @(negedge clk);
    checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("bp_drained", 64'(sb.size()), 64'd0);
    checkOutput("bp_last_tag", {59'd0, last_tag}, 64'd23);

    // Flush while stalled: everything in flight and the offered op vanish.
    out_ready = 1'b0;
    sendOp(mkOp(0, 48'h800000_000000, 0, 0, 9'd10, 0, 3'd0, 5'd24));
    sendOp(mkOp(0, 48'h800000_000000, 1, 0, 9'd11, 0, 3'd0, 5'd25));
    applyStimulus(mkOp(0, 48'h800000_000000, 0, 0, 9'd12, 0, 3'd0, 5'd26));
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("flush_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    p0 = pops;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("flush_no_out", 64'(pops - p0), 64'd0);

    // Reset with two operations in flight.
    sendOp(mkOp(0, 48'hC00000_000000, 0, 0, 9'd90, 0, 3'd0, 5'd27));
    sendOp(mkOp(0, 48'hC00000_000000, 1, 0, 9'd91, 0, 3'd0, 5'd28));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("mid_rst_result", {32'd0, out_result}, 64'd0);
    checkOutput("mid_rst_flags", {59'd0, out_flags}, 64'd0);
    checkOutput("mid_rst_tag", {59'd0, out_tag}, 64'd0);
    checkOutput("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    p0 = pops;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("mid_rst_no_out", 64'(pops - p0), 64'd0);

    // Random traffic with random backpressure.
    for (int c = 0; c < 1500; c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        applyStimulus(genOp());
        in_valid = 1'b1;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("final_drain", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_norm_round_r4.md
# fp_norm_round_r4

Two-stage pipelined normalize/round/pack unit for the single-precision FP add/sub datapath. It sits directly downstream of the mantissa add/sub stage and takes the raw 49-bit sum (carry plus 48-bit mantissa), result sign, sticky bit and pre-normalization exponent. It produces an IEEE-754 binary32 result with RISC-V fflags. Upstream special cases (NaN/Inf/exact operand passthrough) bypass the arithmetic path through the same pipeline so ordering is preserved.

## Interface
Parameters:
- TAG_W, 5, width of the opaque tag carried alongside each operation (e.g. rd index)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  kills all in-flight operations
- in_valid  in  1  input operation valid
- in_ready  out  1  unit can accept this cycle
- in_carry  in  1  sum bit 48
- in_mant  in  48  sum bits 47:0; bit 47 weighs 1.0 at exponent in_exp
- in_sign  in  1  result sign from add/sub stage
- in_sticky  in  1  sticky from alignment/add stage
- in_exp  in  9  biased exponent of larger operand (0..254)
- in_both_zero  in  1  both operands were ±0
- in_rm  in  3  rounding mode: RNE 000, RTZ 001, RDN 010, RUP 011, RMM 100
- in_special  in  1  bypass; output in_special_val and in_special_flags
- in_special_val  in  32  bypass result
- in_special_flags  in  5  bypass flags
- in_tag  in  TAG_W  passthrough tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_result  out  32  binary32 result
- out_flags  out  5  {NV,DZ,OF,UF,NX}
- out_tag  out  TAG_W  tag of result

## Operation
- Stage 1 (normalize), registered:
  - carry=1: shift {carry,mant} right 1; exp+1; shifted-out bit ORs into sticky.
  - otherwise lz = leading zeros of in_mant (0..48); shift = min(lz, exp-1), with exp=0 treated as shift 0; exp_n = exp - shift. If exp - lz ≤ 0, the result is subnormal and exp_n = 0.
  - Zero: mant=0, carry=0, sticky=0.
- Stage 2 (round/pack), registered:
  - sig = norm[47:24]; guard = norm[23]; st = |norm[22:0] | sticky.
  - Round increment: RNE guard&(st|sig[0]); RTZ 0; RDN (guard|st)&sign; RUP (guard|st)&~sign; RMM guard.
  - If sig+inc carries out of 24 bits: sig>>1, exp+1. A subnormal rounding into bit 23 sets exp to 1.
  - Overflow when exp ≥ 255: the result is Inf if (RNE|RMM|(RUP&~sign)|(RDN&sign)), else ±0x7F7FFFFF. Sets OF|NX.
  - NX = guard|st. UF = NX & (rounded exp == 0).
  - Exact zero: if in_both_zero, sign = in_sign. Otherwise (cancellation) sign = (rm==RDN). Flags 0.
  - Special: result and flags are passed through unchanged; arithmetic is ignored.
- NV and DZ come only from the special path.

## Timing
- Latency is 2 cycles from accept (in_valid&in_ready) to out_valid, with no stalls. Throughput is 1 per cycle.
- Stage 2 holds when out_valid&~out_ready. Stage 1 advances iff stage 2 is empty or advancing.
- in_ready = ~s1_valid | s2 advancing. It is combinational from out_ready, which is the only combinational path.
- While out_valid=1 and out_ready=0, out_result, out_flags and out_tag stay stable.
- flush: both valids clear next edge. An input presented in the flush cycle is dropped.
- Reset: s1_valid=s2_valid=0. out_valid=0, out_result=0, out_flags=0, out_tag=0. in_ready=1 from the first cycle after reset.
- Reset mid-operation discards everything. No result emerges.
- Flush and reset take priority over accept.

## Structure
- Package fp_round_pkg:
  - rm_e enum (RNE..RMM)
  - flag bit indices (NV=4..NX=0)
  - constants EXP_MAX=255, MAXFIN=0x7F7FFFFF, PINF=0x7F800000
  - stage-1 payload struct
- Sub-module lzc48: combinational 48-bit leading-zero counter, 6-bit count, 48 on all-zero.

## Test plan
- Basic add and latency: carry=1, mant=0, exp=127, RNE gives 0x40000000, flags 0. out_valid rises exactly 2 cycles after accept.
- Cancellation zero: mant=0, carry=0, sticky=0, both_zero=0.
  - RNE gives 0x00000000.
  - RDN gives 0x80000000.
  - both_zero=1 with sign=1 gives 0x80000000 in any mode.
- Tie rounding: mant[47:24]=0x800001, mant[23]=1, rest 0, exp=127.
  - RNE gives 0x3F800002, NX.
  - RTZ gives 0x3F800001, NX.
  - RMM gives 0x3F800002.
- Overflow: carry=1, mant=0xFFFFFF<<24, exp=254.
  - RNE gives 0x7F800000, OF|NX.
  - RTZ gives 0x7F7FFFFF, OF|NX.
- Subnormal and underflow:
  - exp=1, mant bit 46 only gives 0x00400000, flags 0.
  - Same input with sticky=1 gives 0x00400000, UF|NX.
- Backpressure, flush and reset:
  - Hold out_ready=0 while offering 3 back-to-back ops. Exactly 2 are accepted, in_ready=0 thereafter, and outputs are stable.
  - Release out_ready: results emerge in order with matching tags.
  - flush during a stall: out_valid=0 next cycle.
  - reset mid-stream: all outputs 0 next cycle.
